product_accumulator: RTL and testbench

//  Downstream stage of the 32x32 registered multiplier wrapper. Consumes the 64-bit

---
 rtl/mult_pkg.sv | 24 ++
 rtl/product_accumulator_if.sv | 26 ++
 rtl/product_accumulator_acc_add_ovf.sv | 15 +
 rtl/product_accumulator.sv | 114 +++++++++++
 tb/tb_product_accumulator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier/accumulator datapath: default widths,
// accumulator FSM encoding and a generic sign-extension helper.
package mult_pkg;

   localparam int unsigned PROD_W_D = 64;
   localparam int unsigned ACC_W_D  = 80;
   localparam int unsigned CNT_W_D  = 16;
   localparam int unsigned SEXT_W   = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_e;

   // Sign-extend the low w bits of v to SEXT_W bits (1 <= w <= SEXT_W)
   function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                              input int unsigned       w);
      logic [SEXT_W-1:0] mask;
      mask = (w >= SEXT_W) ? '1 : ((SEXT_W'(1) << w) - SEXT_W'(1));
      return v[7'(w - 1)] ? (v | ~mask) : (v & mask);
   endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in / accumulated result out, both valid/ready handshakes.
interface product_accumulator_if #(
   parameter int unsigned PROD_W = 64,
   parameter int unsigned ACC_W  = 80,
   parameter int unsigned CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_product;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/product_accumulator_acc_add_ovf.sv
// Wide two's-complement adder reporting signed overflow of the W-bit result.
module acc_add_ovf #(
   parameter int unsigned W = 80
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum_c,
   output logic         o_ovf_c
);

   assign o_sum_c = i_a + i_b;
   // Overflow only possible when both addends share a sign
   assign o_ovf_c = (i_a[W-1] == i_b[W-1]) && (o_sum_c[W-1] != i_a[W-1]);

endmodule

// File: rtl/product_accumulator.sv
// Sums signed products until a last-tagged beat (or the term-count limit),
// then holds sum, term count and sticky overflow on a valid/ready output.
module product_accumulator
   import mult_pkg::*;
#(
   parameter int unsigned PROD_W = PROD_W_D,
   parameter int unsigned ACC_W  = ACC_W_D,
   parameter int unsigned CNT_W  = CNT_W_D
) (
   input logic                 clk,
   input logic                 rst_n,
   product_accumulator_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   acc_state_e       r_state,     w_state_nxt;
   logic [ACC_W-1:0] r_acc,       w_acc_nxt;
   logic [CNT_W-1:0] r_count,     w_count_nxt;
   logic             r_ovf,       w_ovf_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic [ACC_W-1:0] r_out_sum,   w_out_sum_nxt;
   logic [CNT_W-1:0] r_out_count, w_out_count_nxt;
   logic             r_out_ovf,   w_out_ovf_nxt;

   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_add_sum;
   logic             w_add_ovf;
   logic             w_ready;
   logic             w_accept;
   logic             w_take;

   assign w_ext = ACC_W'(sext(SEXT_W'(bus.in_product), PROD_W));

   acc_add_ovf #(.W(ACC_W)) u_add (
      .i_a     (r_acc),
      .i_b     (w_ext),
      .o_sum_c (w_add_sum),
      .o_ovf_c (w_add_ovf)
   );

   // Ready depends only on state and out_ready so a full DONE can take and accept together
   assign w_ready  = (r_state != DONE) || bus.out_ready;
   assign w_accept = bus.in_valid && w_ready;
   assign w_take   = r_out_valid && bus.out_ready;

   // Next-state, accumulator and result-register logic
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_count_nxt     = r_count;
      w_ovf_nxt       = r_ovf;
      w_out_valid_nxt = r_out_valid;
      w_out_sum_nxt   = r_out_sum;
      w_out_count_nxt = r_out_count;
      w_out_ovf_nxt   = r_out_ovf;

      if (w_take) begin
         w_out_valid_nxt = 1'b0;
         w_state_nxt     = IDLE;
      end

      if (w_accept) begin
         if (r_state == ACCUM) begin
            w_acc_nxt   = w_add_sum;
            w_count_nxt = r_count + CNT_W'(1);
            w_ovf_nxt   = r_ovf | w_add_ovf;
         end else begin
            w_acc_nxt   = w_ext;
            w_count_nxt = CNT_W'(1);
            w_ovf_nxt   = 1'b0;
         end

         if (bus.in_last || (w_count_nxt == CNT_MAX)) begin
            w_state_nxt     = DONE;
            w_out_valid_nxt = 1'b1;
            w_out_sum_nxt   = w_acc_nxt;
            w_out_count_nxt = w_count_nxt;
            w_out_ovf_nxt   = w_ovf_nxt;
         end else begin
            w_state_nxt = ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_count     <= w_count_nxt;
         r_ovf       <= w_ovf_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_sum   <= w_out_sum_nxt;
         r_out_count <= w_out_count_nxt;
         r_out_ovf   <= w_out_ovf_nxt;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_count = r_out_count;
   assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: three builds (default, 64-bit accumulator, 3-bit counter)
// driven by directed and random product streams.
module tb_product_accumulator;

   typedef struct {
      logic [127:0] sum;
      int unsigned  cnt;
      bit           ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  tb_valid = '0;
   logic [2:0]  tb_last  = '0;
   logic [2:0]  tb_ordy  = '1;
   logic [63:0] tb_prod [3];
   logic [2:0]  rdy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          rnd_on = 1'b0;

   int unsigned  aw   [3] = '{80, 64, 80};
   int unsigned  cmax [3] = '{65535, 65535, 7};
   logic [127:0] m_acc  [3];
   int unsigned  m_cnt  [3];
   bit           m_ovf  [3];
   bit           m_busy [3];
   exp_t         sbq [3][$];

   always #5 clk = ~clk;

   product_accumulator_if #(.PROD_W(64), .ACC_W(80), .CNT_W(16)) bus0 ();
   product_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) bus1 ();
   product_accumulator_if #(.PROD_W(64), .ACC_W(80), .CNT_W(3))  bus2 ();

   product_accumulator #(.PROD_W(64), .ACC_W(80), .CNT_W(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   product_accumulator #(.PROD_W(64), .ACC_W(80), .CNT_W(3))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   assign bus0.in_valid = tb_valid[0]; assign bus0.in_last = tb_last[0];
   assign bus0.in_product = tb_prod[0]; assign bus0.out_ready = tb_ordy[0];
   assign bus1.in_valid = tb_valid[1]; assign bus1.in_last = tb_last[1];
   assign bus1.in_product = tb_prod[1]; assign bus1.out_ready = tb_ordy[1];
   assign bus2.in_valid = tb_valid[2]; assign bus2.in_last = tb_last[2];
   assign bus2.in_product = tb_prod[2]; assign bus2.out_ready = tb_ordy[2];
   assign rdy[0] = bus0.in_ready;
   assign rdy[1] = bus1.in_ready;
   assign rdy[2] = bus2.in_ready;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Compare held/taken results against the queue head; model accepted beats
   task automatic mon(input int d, input bit iv, input bit ir, input logic [63:0] p,
                      input bit il, input bit ov, input bit ordy,
                      input logic [127:0] sum, input int unsigned cnt, input bit ovf);
      exp_t         e;
      logic [127:0] mask, pe, s;
      logic [6:0]   sb;
      if (!rst_n) begin
         m_busy[d] = 1'b0;
         sbq[d].delete();
         return;
      end
      if (ov) begin
         check($sformatf("sb_empty%0d", d), 128'(sbq[d].size() == 0), 128'(0));
         if (sbq[d].size() != 0) begin
            e = sbq[d][0];
            check($sformatf("sum%0d", d), sum, e.sum);
            check($sformatf("count%0d", d), 128'(cnt), 128'(e.cnt));
            check($sformatf("ovf%0d", d), 128'(ovf), 128'(e.ovf));
            if (ordy) void'(sbq[d].pop_front());
         end
      end
      if (iv && ir) begin
         mask = (128'(1) << aw[d]) - 128'(1);
         pe   = 128'($signed(p)) & mask;
         sb   = 7'(aw[d] - 1);
         if (!m_busy[d]) begin
            m_acc[d] = pe;
            m_cnt[d] = 1;
            m_ovf[d] = 1'b0;
         end else begin
            s = (m_acc[d] + pe) & mask;
            if ((m_acc[d][sb] == pe[sb]) && (s[sb] != m_acc[d][sb])) m_ovf[d] = 1'b1;
            m_acc[d] = s;
            m_cnt[d]++;
         end
         if (il || (m_cnt[d] == cmax[d])) begin
            e.sum = m_acc[d]; e.cnt = m_cnt[d]; e.ovf = m_ovf[d];
            sbq[d].push_back(e);
            m_busy[d] = 1'b0;
         end else begin
            m_busy[d] = 1'b1;
         end
      end
   endtask

   always @(negedge clk) mon(0, bus0.in_valid, bus0.in_ready, bus0.in_product, bus0.in_last,
                             bus0.out_valid, bus0.out_ready, 128'(bus0.out_sum),
                             32'(bus0.out_count), bus0.out_ovf);
   always @(negedge clk) mon(1, bus1.in_valid, bus1.in_ready, bus1.in_product, bus1.in_last,
                             bus1.out_valid, bus1.out_ready, 128'(bus1.out_sum),
                             32'(bus1.out_count), bus1.out_ovf);
   always @(negedge clk) mon(2, bus2.in_valid, bus2.in_ready, bus2.in_product, bus2.in_last,
                             bus2.out_valid, bus2.out_ready, 128'(bus2.out_sum),
                             32'(bus2.out_count), bus2.out_ovf);

   // Present one beat and return 1 time unit after the edge that accepts it
   task automatic send(input int d, input logic [63:0] p, input bit last);
      int unsigned n = 0;
      tb_valid[d] = 1'b1;
      tb_prod[d]  = p;
      tb_last[d]  = last;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[d] && n < 200);
      check($sformatf("accept%0d", d), 128'(rdy[d]), 128'(1));
      @(posedge clk);
      #1;
      tb_valid[d] = 1'b0;
   endtask

   initial begin
      tb_prod[0] = 64'd123; tb_prod[1] = '0; tb_prod[2] = '0;
      tb_valid   = 3'b001;
      tb_last    = 3'b001;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(bus0.in_ready), 128'(1));
      check("rst_out_valid", 128'(bus0.out_valid), 128'(0));
      check("rst_out_sum", 128'(bus0.out_sum), 128'(0));
      check("rst_out_count", 128'(bus0.out_count), 128'(0));
      check("rst_out_ovf", 128'(bus0.out_ovf), 128'(0));
      tb_valid = '0;
      tb_last  = '0;
      rst_n    = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a sum discards it
      send(0, 64'd4, 1'b0);
      send(0, 64'd6, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_valid", 128'(bus0.out_valid), 128'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, 64'd2, 1'b1);
      check("midrst_sum", 128'(bus0.out_sum), 128'(2));
      check("midrst_count", 128'(bus0.out_count), 128'(1));

      // Three-term dot product; result valid for exactly one cycle
      send(0, 64'd5, 1'b0);
      send(0, -64'sd2, 1'b0);
      send(0, 64'd10, 1'b1);
      check("t2_valid", 128'(bus0.out_valid), 128'(1));
      check("t2_sum", 128'(bus0.out_sum), 128'(13));
      check("t2_count", 128'(bus0.out_count), 128'(3));
      check("t2_ovf", 128'(bus0.out_ovf), 128'(0));
      @(posedge clk); #1;
      check("t2_valid_drop", 128'(bus0.out_valid), 128'(0));

      // Backpressure: result held, no new beat accepted until taken
      tb_ordy[0] = 1'b0;
      send(0, 64'd7, 1'b1);
      fork
         send(0, 64'd1, 1'b1);
         begin
            repeat (4) begin
               @(posedge clk); #2;
               check("bp_valid", 128'(bus0.out_valid), 128'(1));
               check("bp_sum", 128'(bus0.out_sum), 128'(7));
               check("bp_in_ready", 128'(bus0.in_ready), 128'(0));
            end
            tb_ordy[0] = 1'b1;
         end
      join
      check("bp_next_sum", 128'(bus0.out_sum), 128'(1));

      // Back-to-back: take and accept in the same cycle, no bubble
      send(0, 64'd9, 1'b1);
      send(0, 64'd3, 1'b1);
      check("b2b_valid", 128'(bus0.out_valid), 128'(1));
      check("b2b_sum", 128'(bus0.out_sum), 128'(3));
      check("b2b_count", 128'(bus0.out_count), 128'(1));

      // Random products, gaps and consumer stalls
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
               send(0, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk); #1;
               tb_ordy[0] = 1'($urandom_range(0, 1));
            end
         end
      join
      tb_ordy[0] = 1'b1;

      // Signed overflow of a 64-bit accumulator
      send(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      send(1, 64'd1, 1'b1);
      check("ovf_sum", 128'(bus1.out_sum), 128'(64'h8000_0000_0000_0000));
      check("ovf_flag", 128'(bus1.out_ovf), 128'(1));
      send(1, 64'd1, 1'b1);
      check("ovf_clear_sum", 128'(bus1.out_sum), 128'(1));
      check("ovf_clear_flag", 128'(bus1.out_ovf), 128'(0));
      send(1, 64'h8000_0000_0000_0000, 1'b0);
      send(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      check("ovf_neg_sum", 128'(bus1.out_sum), 128'(64'h7FFF_FFFF_FFFF_FFFF));
      check("ovf_neg_flag", 128'(bus1.out_ovf), 128'(1));

      // Term-count limit on a 3-bit counter forces completion at 7
      for (int i = 0; i < 7; i++) send(2, 64'd1, 1'b0);
      check("lim_valid", 128'(bus2.out_valid), 128'(1));
      check("lim_sum", 128'(bus2.out_sum), 128'(7));
      check("lim_count", 128'(bus2.out_count), 128'(7));
      send(2, 64'd1, 1'b0);
      check("lim_next_pending", 128'(bus2.out_valid), 128'(0));
      send(2, 64'd0, 1'b1);
      check("lim_next_sum", 128'(bus2.out_sum), 128'(1));
      check("lim_next_count", 128'(bus2.out_count), 128'(2));

      tb_ordy = '1;
      repeat (5) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("drain%0d", d), 128'(sbq[d].size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
